// File: rtl/mac_result_collector_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mac_result_collector_if                                 |
// | Description : Valid/ready handshake carrying completed group sums     |
// |               from the collector to its downstream consumer.          |
// |   valid : head entry available (master -> slave)                      |
// |   ready : consumer accepts the head (slave -> master)                 |
// |   data  : completed group sum, DATA_WIDTH bits (master -> slave)      |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface mac_result_collector_if #(
  parameter int DATA_WIDTH = 26
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/mac_result_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mac_result_collector                                    |
// | Description : Accumulates GROUP_LEN consecutive MAC partial sums into |
// |               one output-channel sum, buffers completed sums in a     |
// |               first-word-fall-through FIFO and hands them downstream. |
// |               Flags (sticky) any completed sum the FIFO had to drop.  |
// | Ports       : clk, nrst (async active-low), clear (sync flush),       |
// |               group_len, valid_in, in_res  - MAC result stream        |
// |               out_if (master)              - valid/ready/data output  |
// |               fifo_level, busy, overflow   - status                   |
// |               sat_flag                     - only with the macro      |
// | Option      : MAC_COLLECTOR_SAT_EN - saturating accumulator plus a    |
// |               sticky sat_flag output; otherwise modulo wrap.          |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module mac_result_collector #(
  parameter  int IN_WIDTH   = 18,
  parameter  int ACC_GUARD  = 8,
  parameter  int LEN_WIDTH  = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int ACC_WIDTH  = IN_WIDTH + ACC_GUARD,
  localparam int LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  wire logic                 clk,
  input  wire logic                 nrst,
  input  wire logic                 clear,
  input  wire logic [LEN_WIDTH-1:0] group_len,
  input  wire logic                 valid_in,
  input  wire logic [IN_WIDTH-1:0]  in_res,
  mac_result_collector_if.master    out_if,
  output logic [LVL_WIDTH-1:0]      fifo_level,
  output logic                      busy,
  output logic                      overflow
`ifdef MAC_COLLECTOR_SAT_EN
  ,
  output logic                      sat_flag
`endif
);

  localparam int       PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic [0:0]           r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [LEN_WIDTH-1:0] r_len;
  logic [ACC_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] r_wr_ptr;
  logic [PTR_WIDTH-1:0] r_rd_ptr;
  logic [LVL_WIDTH-1:0] r_level;
  logic                 r_overflow;

  logic [LEN_WIDTH-1:0] w_len_eff;
  logic [LEN_WIDTH-1:0] w_cnt_next;
  logic [ACC_WIDTH-1:0] w_base;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_last;
  logic                 w_complete;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;

  // A zero group length is treated as a single-beat group.
  assign w_len_eff  = (group_len == '0) ? LEN_WIDTH'(1) : group_len;
  assign w_cnt_next = r_cnt + LEN_WIDTH'(1);

  // The first beat of a group adds onto zero, so the same adder serves both states.
  assign w_base = (r_state == S_ACCUM) ? r_acc : '0;

`ifdef MAC_COLLECTOR_SAT_EN
  logic [ACC_WIDTH:0] w_sum_ext;
  logic               w_carry;
  logic               r_sat_flag;

  assign w_sum_ext = {1'b0, w_base} + (ACC_WIDTH+1)'(in_res);
  assign w_carry   = w_sum_ext[ACC_WIDTH];
  assign w_sum     = w_carry ? '1 : w_sum_ext[ACC_WIDTH-1:0];
  assign sat_flag  = r_sat_flag;
`else
  assign w_sum = w_base + ACC_WIDTH'(in_res);
`endif

  // r_len is only meaningful in ACCUM; in IDLE the live group_len decides.
  assign w_last     = (r_state == S_IDLE) ? (w_len_eff == LEN_WIDTH'(1)) : (w_cnt_next == r_len);
  assign w_complete = valid_in & w_last;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_WIDTH'(FIFO_DEPTH));
  assign w_pop   = ~w_empty & out_if.ready;
  // A pop on a full FIFO frees the slot the push needs in the same cycle.
  assign w_push  = w_complete & (~w_full | w_pop);
  assign w_drop  = w_complete & w_full & ~w_pop;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
`ifdef MAC_COLLECTOR_SAT_EN
      r_sat_flag <= 1'b0;
`endif
    end else if (clear) begin
      // Flush wins over any coincident beat or pop.
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
`ifdef MAC_COLLECTOR_SAT_EN
      r_sat_flag <= 1'b0;
`endif
    end else begin
      if (valid_in) begin
        case (r_state)
          S_IDLE: begin
            r_len <= w_len_eff;
            if (!w_last) begin
              r_acc   <= w_sum;
              r_cnt   <= LEN_WIDTH'(1);
              r_state <= S_ACCUM;
            end
          end
          default: begin
            if (w_last) begin
              r_acc   <= '0;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_acc <= w_sum;
              r_cnt <= w_cnt_next;
            end
          end
        endcase
      end

      if (w_push) begin
        r_mem[r_wr_ptr] <= w_sum;
        r_wr_ptr        <= r_wr_ptr + PTR_WIDTH'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_WIDTH'(1);
        2'b01:   r_level <= r_level - LVL_WIDTH'(1);
        default: r_level <= r_level;
      endcase

      if (w_drop) r_overflow <= 1'b1;
`ifdef MAC_COLLECTOR_SAT_EN
      if (valid_in && w_carry) r_sat_flag <= 1'b1;
`endif
    end
  end

  assign out_if.valid = ~w_empty;
  assign out_if.data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign fifo_level   = r_level;
  assign busy         = (r_state == S_ACCUM);
  assign overflow     = r_overflow;

endmodule
`default_nettype wire
